// File: rtl/slave_if_rd.sv
// slave_if_rd: slave-side read port of the crossbar.
// Four masters compete round-robin for one single-port, 1-cycle-latency
// buffer-memory read port. A grant is held for a whole burst and released on
// the Last beat, on a Req drop (abort) or when the beat watchdog fires.
//
// Ports:
//   iClk, iRst_n                  clock, async active-low reset
//   iMstNRdReq/Valid/Addr/Sel/Last per-master request and beat bundle (N=0..3)
//   oMstNRdReady                  beat accept, granted master only
//   oMstNRdData                   broadcast copy of iMemRdData
//   oMemRdEn/Addr/Sel, iMemRdData memory read port
//   oGrant                        one-hot owner, 0 when idle
//   oBurstErr                     1-cycle pulse after a watchdog release
//
// state | meaning
// IDLE  | no owner; arbitrate among requesters, grant takes effect next cycle
// BUSY  | grant locked; beats of the owner go straight to memory
module slave_if_rd #(
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int SW        = 4,
  parameter int MAX_BURST = 64
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iMst0RdReq,
  input  logic          iMst1RdReq,
  input  logic          iMst2RdReq,
  input  logic          iMst3RdReq,
  input  logic          iMst0RdValid,
  input  logic          iMst1RdValid,
  input  logic          iMst2RdValid,
  input  logic          iMst3RdValid,
  input  logic [AW-1:0] iMst0RdAddr,
  input  logic [AW-1:0] iMst1RdAddr,
  input  logic [AW-1:0] iMst2RdAddr,
  input  logic [AW-1:0] iMst3RdAddr,
  input  logic [SW-1:0] iMst0RdSel,
  input  logic [SW-1:0] iMst1RdSel,
  input  logic [SW-1:0] iMst2RdSel,
  input  logic [SW-1:0] iMst3RdSel,
  input  logic          iMst0RdLast,
  input  logic          iMst1RdLast,
  input  logic          iMst2RdLast,
  input  logic          iMst3RdLast,
  output logic          oMst0RdReady,
  output logic          oMst1RdReady,
  output logic          oMst2RdReady,
  output logic          oMst3RdReady,
  output logic [DW-1:0] oMst0RdData,
  output logic [DW-1:0] oMst1RdData,
  output logic [DW-1:0] oMst2RdData,
  output logic [DW-1:0] oMst3RdData,
  output logic          oMemRdEn,
  output logic [AW-1:0] oMemRdAddr,
  output logic [SW-1:0] oMemRdSel,
  input  logic [DW-1:0] iMemRdData,
  output logic [3:0]    oGrant,
  output logic          oBurstErr
);

  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [3:0]      grant;
  logic [1:0]      gnt_idx;
  logic [1:0]      ptr;
  logic [CW-1:0]   cnt;
  logic            burst_err;

  logic [3:0]      req_v, vld_v, lst_v;
  logic [AW-1:0]   addr_v [4];
  logic [SW-1:0]   sel_v  [4];

  logic            cur_req, cur_vld, cur_lst;
  logic [AW-1:0]   cur_addr;
  logic [SW-1:0]   cur_sel;
  logic            busy, accept, wd_hit, release_now;
  logic            arb_found;
  logic [1:0]      arb_idx, cand;

  assign req_v  = {iMst3RdReq,   iMst2RdReq,   iMst1RdReq,   iMst0RdReq};
  assign vld_v  = {iMst3RdValid, iMst2RdValid, iMst1RdValid, iMst0RdValid};
  assign lst_v  = {iMst3RdLast,  iMst2RdLast,  iMst1RdLast,  iMst0RdLast};
  assign addr_v = '{iMst0RdAddr, iMst1RdAddr, iMst2RdAddr, iMst3RdAddr};
  assign sel_v  = '{iMst0RdSel,  iMst1RdSel,  iMst2RdSel,  iMst3RdSel};

  // Owner bundle is selected by the registered grant index only, so a
  // non-owner's Addr/Sel can never leak into the memory port.
  assign cur_req  = req_v[gnt_idx];
  assign cur_vld  = vld_v[gnt_idx];
  assign cur_lst  = lst_v[gnt_idx];
  assign cur_addr = addr_v[gnt_idx];
  assign cur_sel  = sel_v[gnt_idx];

  assign busy        = (state == BUSY);
  assign accept      = busy & cur_req & cur_vld;
  assign wd_hit      = accept & (cnt == CW'(MAX_BURST - 1));
  assign release_now = busy & (~cur_req | (accept & cur_lst) | wd_hit);

  // Search starts just after the last owner; k=4 wraps back to ptr itself.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr;
    cand      = ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!arb_found && req_v[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state     <= IDLE;
      grant     <= '0;
      gnt_idx   <= '0;
      ptr       <= 2'd3;
      cnt       <= '0;
      burst_err <= 1'b0;
    end else begin
      burst_err <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_found) begin
            state   <= BUSY;
            grant   <= 4'(1) << arb_idx;
            gnt_idx <= arb_idx;
          end
        end
        BUSY: begin
          if (accept && cnt != CW'(MAX_BURST))
            cnt <= cnt + 1'b1;
          if (release_now) begin
            state     <= IDLE;
            grant     <= '0;
            ptr       <= gnt_idx;
            cnt       <= '0;
            burst_err <= wd_hit & ~cur_lst;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oGrant       = grant;
  assign oBurstErr    = burst_err;
  assign oMst0RdReady = busy & grant[0];
  assign oMst1RdReady = busy & grant[1];
  assign oMst2RdReady = busy & grant[2];
  assign oMst3RdReady = busy & grant[3];

  assign oMemRdEn   = accept;
  assign oMemRdAddr = accept ? cur_addr : '0;
  assign oMemRdSel  = accept ? cur_sel  : '0;

  assign oMst0RdData = iMemRdData;
  assign oMst1RdData = iMemRdData;
  assign oMst2RdData = iMemRdData;
  assign oMst3RdData = iMemRdData;

endmodule

// File: tb/tb_slave_if_rd.sv
// tb_slave_if_rd: table-driven bench for slave_if_rd (watchdog set to 4 beats).
// Each row is one clock cycle: inputs applied just after the rising edge,
// outputs compared on the falling edge. Master N drives addr = a + N*0x100
// and sel = N+1, so the memory port reveals which master was forwarded.
module tb_slave_if_rd;

  localparam int AW = 12, DW = 32, SW = 4, MB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req [4], vld [4], lst [4];
  logic [AW-1:0] addr [4];
  logic [SW-1:0] sel [4];
  logic          rdy [4];
  logic [DW-1:0] dout [4];
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_sel;
  logic [DW-1:0] mem_data = '0;
  logic [3:0]    grant;
  logic          burst_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  slave_if_rd #(.AW(AW), .DW(DW), .SW(SW), .MAX_BURST(MB)) dut (
    .iClk(clk), .iRst_n(rst_n),
    .iMst0RdReq(req[0]), .iMst1RdReq(req[1]), .iMst2RdReq(req[2]), .iMst3RdReq(req[3]),
    .iMst0RdValid(vld[0]), .iMst1RdValid(vld[1]), .iMst2RdValid(vld[2]), .iMst3RdValid(vld[3]),
    .iMst0RdAddr(addr[0]), .iMst1RdAddr(addr[1]), .iMst2RdAddr(addr[2]), .iMst3RdAddr(addr[3]),
    .iMst0RdSel(sel[0]), .iMst1RdSel(sel[1]), .iMst2RdSel(sel[2]), .iMst3RdSel(sel[3]),
    .iMst0RdLast(lst[0]), .iMst1RdLast(lst[1]), .iMst2RdLast(lst[2]), .iMst3RdLast(lst[3]),
    .oMst0RdReady(rdy[0]), .oMst1RdReady(rdy[1]), .oMst2RdReady(rdy[2]), .oMst3RdReady(rdy[3]),
    .oMst0RdData(dout[0]), .oMst1RdData(dout[1]), .oMst2RdData(dout[2]), .oMst3RdData(dout[3]),
    .oMemRdEn(mem_en), .oMemRdAddr(mem_addr), .oMemRdSel(mem_sel), .iMemRdData(mem_data),
    .oGrant(grant), .oBurstErr(burst_err)
  );

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return {8'hD0, 8'h0D, 4'h0, a};
  endfunction

  // 1-cycle-latency buffer memory
  always @(posedge clk) if (mem_en) mem_data <= mem_fn(mem_addr);

  typedef struct {
    bit          rst;
    logic [3:0]  req, vld, lst;
    logic [11:0] a;
    logic [3:0]  g;
    logic        en;
    logic [11:0] ma;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input bit r, input logic [3:0] rq, input logic [3:0] vl,
                            input logic [3:0] ls, input logic [11:0] a, input logic [3:0] g,
                            input logic en, input logic [11:0] ma, input logic err);
    vec_t t;
    t.rst = r; t.req = rq; t.vld = vl; t.lst = ls; t.a = a;
    t.g = g; t.en = en; t.ma = ma; t.err = err;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] rdy_vec();
    return {rdy[3], rdy[2], rdy[1], rdy[0]};
  endfunction

  task automatic drive(input logic [3:0] rq, input logic [3:0] vl, input logic [3:0] ls,
                       input logic [11:0] a);
    for (int n = 0; n < 4; n++) begin
      req[n]  = rq[n];
      vld[n]  = vl[n];
      lst[n]  = ls[n];
      addr[n] = a + 12'(n * 256);
      sel[n]  = 4'(n + 1);
    end
  endtask

  logic        prev_en;
  logic [11:0] prev_ma;
  logic [3:0]  exp_sel;

  initial begin
    // single burst M2, 4 beats, Last on 4th (also reaches watchdog count with Last=1)
    v(0,4'b0100,4'b0000,4'b0000,12'h000, 4'b0000,0,12'h000,0);
    v(0,4'b0100,4'b0100,4'b0000,12'h010, 4'b0100,1,12'h210,0);
    v(0,4'b0100,4'b0100,4'b0000,12'h011, 4'b0100,1,12'h211,0);
    v(0,4'b0100,4'b0100,4'b0000,12'h012, 4'b0100,1,12'h212,0);
    v(0,4'b0100,4'b0100,4'b0100,12'h013, 4'b0100,1,12'h213,0);
    v(0,4'b0000,4'b0000,4'b0000,12'h000, 4'b0000,0,12'h000,0);
    // contention from reset: 2-beat bursts, order M0,M1,M2,M3,M0
    v(1,4'b1111,4'b1111,4'b0000,12'h000, 4'b0000,0,12'h000,0);
    v(0,4'b1111,4'b1111,4'b0000,12'h020, 4'b0001,1,12'h020,0);
    v(0,4'b1111,4'b1111,4'b1111,12'h021, 4'b0001,1,12'h021,0);
    v(0,4'b1111,4'b1111,4'b0000,12'h000, 4'b0000,0,12'h000,0);
    v(0,4'b1111,4'b1111,4'b0000,12'h030, 4'b0010,1,12'h130,0);
    v(0,4'b1111,4'b1111,4'b1111,12'h031, 4'b0010,1,12'h131,0);
    v(0,4'b1111,4'b1111,4'b0000,12'h000, 4'b0000,0,12'h000,0);
    v(0,4'b1111,4'b1111,4'b0000,12'h040, 4'b0100,1,12'h240,0);
    v(0,4'b1111,4'b1111,4'b1111,12'h041, 4'b0100,1,12'h241,0);
    v(0,4'b1111,4'b1111,4'b0000,12'h000, 4'b0000,0,12'h000,0);
    v(0,4'b1111,4'b1111,4'b0000,12'h050, 4'b1000,1,12'h350,0);
    v(0,4'b1111,4'b1111,4'b1111,12'h051, 4'b1000,1,12'h351,0);
    v(0,4'b1111,4'b1111,4'b0000,12'h000, 4'b0000,0,12'h000,0);
    v(0,4'b1111,4'b1111,4'b0000,12'h060, 4'b0001,1,12'h060,0);
    v(0,4'b0000,4'b1111,4'b1111,12'h061, 4'b0001,0,12'h000,0);
    v(0,4'b0000,4'b0000,4'b0000,12'h000, 4'b0000,0,12'h000,0);
    // gap beats on M1; M0 Valid without grant is ignored
    v(0,4'b0010,4'b0000,4'b0000,12'h000, 4'b0000,0,12'h000,0);
    v(0,4'b0010,4'b0010,4'b0000,12'h070, 4'b0010,1,12'h170,0);
    v(0,4'b0010,4'b0001,4'b0000,12'h000, 4'b0010,0,12'h000,0);
    v(0,4'b0010,4'b0001,4'b0000,12'h000, 4'b0010,0,12'h000,0);
    v(0,4'b0010,4'b0010,4'b0010,12'h071, 4'b0010,1,12'h171,0);
    v(0,4'b0000,4'b0000,4'b0000,12'h000, 4'b0000,0,12'h000,0);
    // abort: M3 drops Req after 2 beats; ptr=3 so M0 wins next
    v(0,4'b1000,4'b0000,4'b0000,12'h000, 4'b0000,0,12'h000,0);
    v(0,4'b1000,4'b1000,4'b0000,12'h080, 4'b1000,1,12'h380,0);
    v(0,4'b1000,4'b1000,4'b0000,12'h081, 4'b1000,1,12'h381,0);
    v(0,4'b0000,4'b1000,4'b0000,12'h082, 4'b1000,0,12'h000,0);
    v(0,4'b1111,4'b0000,4'b0000,12'h000, 4'b0000,0,12'h000,0);
    v(0,4'b1111,4'b0000,4'b0000,12'h000, 4'b0001,0,12'h000,0);
    v(0,4'b0000,4'b0000,4'b0000,12'h000, 4'b0001,0,12'h000,0);
    v(0,4'b0000,4'b0000,4'b0000,12'h000, 4'b0000,0,12'h000,0);
    // watchdog: M0 streams without Last; 4 beats accepted, then pulse
    v(0,4'b0001,4'b0000,4'b0000,12'h000, 4'b0000,0,12'h000,0);
    v(0,4'b0001,4'b0001,4'b0000,12'h090, 4'b0001,1,12'h090,0);
    v(0,4'b0001,4'b0001,4'b0000,12'h091, 4'b0001,1,12'h091,0);
    v(0,4'b0001,4'b0001,4'b0000,12'h092, 4'b0001,1,12'h092,0);
    v(0,4'b0001,4'b0001,4'b0000,12'h093, 4'b0001,1,12'h093,0);
    v(0,4'b0001,4'b0001,4'b0000,12'h094, 4'b0000,0,12'h000,1);
    v(0,4'b0000,4'b0001,4'b0000,12'h095, 4'b0001,0,12'h000,0);
    v(0,4'b0000,4'b0000,4'b0000,12'h000, 4'b0000,0,12'h000,0);

    drive(4'b0000, 4'b0000, 4'b0000, 12'h000);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ready", 32'(rdy_vec()), 32'h0);
    chk("rst_memen", 32'(mem_en), 32'h0);
    chk("rst_addr",  32'(mem_addr), 32'h0);
    chk("rst_sel",   32'(mem_sel), 32'h0);
    chk("rst_err",   32'(burst_err), 32'h0);
    rst_n = 1'b1;

    prev_en = 1'b0;
    prev_ma = '0;
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      if (vecs[i].rst) begin
        rst_n = 1'b0; #1; rst_n = 1'b1;
        prev_en = 1'b0;
      end
      drive(vecs[i].req, vecs[i].vld, vecs[i].lst, vecs[i].a);
      @(negedge clk);
      exp_sel = '0;
      for (int n = 0; n < 4; n++) if (vecs[i].g[n]) exp_sel = 4'(n + 1);
      chk($sformatf("grant[%0d]", i), 32'(grant), 32'(vecs[i].g));
      chk($sformatf("ready[%0d]", i), 32'(rdy_vec()), 32'(vecs[i].g));
      chk($sformatf("memen[%0d]", i), 32'(mem_en), 32'(vecs[i].en));
      chk($sformatf("berr[%0d]", i), 32'(burst_err), 32'(vecs[i].err));
      if (vecs[i].en) begin
        chk($sformatf("maddr[%0d]", i), 32'(mem_addr), 32'(vecs[i].ma));
        chk($sformatf("msel[%0d]", i), 32'(mem_sel), 32'(exp_sel));
      end
      if (prev_en)
        for (int n = 0; n < 4; n++)
          chk($sformatf("data%0d[%0d]", n, i), dout[n], mem_fn(prev_ma));
      prev_en = vecs[i].en;
      prev_ma = vecs[i].ma;
    end

    // reset in the middle of an M1 burst
    @(posedge clk); #1;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    drive(4'b0010, 4'b0000, 4'b0000, 12'h000);
    @(negedge clk);
    chk("mr_idle_grant", 32'(grant), 32'h0);
    @(posedge clk); #1;
    drive(4'b0010, 4'b0010, 4'b0000, 12'h0A0);
    @(negedge clk);
    chk("mr_beat1_grant", 32'(grant), 32'h2);
    chk("mr_beat1_addr", 32'(mem_addr), 32'h1A0);
    @(posedge clk); #1;
    drive(4'b0011, 4'b0011, 4'b0000, 12'h0A1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_grant", 32'(grant), 32'h0);
    chk("mr_ready", 32'(rdy_vec()), 32'h0);
    chk("mr_memen", 32'(mem_en), 32'h0);
    chk("mr_addr",  32'(mem_addr), 32'h0);
    chk("mr_err",   32'(burst_err), 32'h0);
    @(posedge clk); #1;
    chk("mr_hold_memen", 32'(mem_en), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_rel_grant", 32'(grant), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_m0_grant", 32'(grant), 32'h1);
    chk("mr_m0_ready", 32'(rdy_vec()), 32'h1);
    chk("mr_m0_addr",  32'(mem_addr), 32'h0A1);
    drive(4'b0000, 4'b0000, 4'b0000, 12'h000);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
